// File: rtl/sra_shift_unit.sv
// 16-bit arithmetic shift-right unit: four-stage logarithmic barrel shifter
// (shift by 1, 2, 4, 8), with valid carried alongside the data and a global stall.
module sra_shift_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic             neg
);

    // One conditional sign-filling shift; the MSB of d is always the original sign.
    function automatic logic signed [WIDTH-1:0] sra_step(
        input logic signed [WIDTH-1:0] d,
        input logic                    sel,
        input int unsigned             amt
    );
        return sel ? (d >>> amt) : d;
    endfunction

    logic signed [WIDTH-1:0] data_p0, data_p1, data_p2, data_p3;
    logic        [SHW-2:0]   sh_p0;
    logic        [SHW-3:0]   sh_p1;
    logic                    sh_p2;
    logic                    vld_p0, vld_p1, vld_p2, vld_p3;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            data_p0 <= '0;
            data_p1 <= '0;
            data_p2 <= '0;
            data_p3 <= '0;
            sh_p0   <= '0;
            sh_p1   <= '0;
            sh_p2   <= 1'b0;
        end else if (en) begin
            // stage 0: shift by 1
            vld_p0  <= in_valid;
            data_p0 <= sra_step($signed(A), shamt[0], 1);
            sh_p0   <= shamt[SHW-1:1];
            // stage 1: shift by 2
            vld_p1  <= vld_p0;
            data_p1 <= sra_step(data_p0, sh_p0[0], 2);
            sh_p1   <= sh_p0[SHW-2:1];
            // stage 2: shift by 4
            vld_p2  <= vld_p1;
            data_p2 <= sra_step(data_p1, sh_p1[0], 4);
            sh_p2   <= sh_p1[SHW-3];
            // stage 3: shift by 8
            vld_p3  <= vld_p2;
            data_p3 <= sra_step(data_p2, sh_p2, 8);
        end
    end

    assign out       = data_p3;
    assign out_valid = vld_p3;
    assign zero      = (data_p3 == '0);
    assign neg       = data_p3[WIDTH-1];

endmodule

// File: tb/tb_sra_shift_unit.sv
// Self-checking bench for sra_shift_unit: directed vectors plus a cycle-by-cycle
// reference of "A >>> shamt, delivered four enabled cycles later".
module tb_sra_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] A = '0;
    logic [3:0]  shamt = '0;
    logic [15:0] out;
    logic        out_valid, zero, neg;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference: results of the last four enabled cycles, newest first.
    logic        ref_v [4] = '{default: 1'b0};
    logic [15:0] ref_d [4] = '{default: 16'h0000};

    logic [15:0] held_out;
    logic        held_v;

    sra_shift_unit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .A         (A),
        .shamt     (shamt),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_sra(input logic [15:0] a, input logic [3:0] s);
        logic signed [15:0] t;
        t = a;
        return t >>> s;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ref_v[i] <= 1'b0;
                ref_d[i] <= 16'h0000;
            end
        end else if (en) begin
            ref_v[0] <= in_valid;
            ref_d[0] <= ref_sra(A, shamt);
            for (int i = 1; i < 4; i++) begin
                ref_v[i] <= ref_v[i-1];
                ref_d[i] <= ref_d[i-1];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_out_valid", {15'd0, out_valid}, {15'd0, ref_v[3]});
            if (ref_v[3]) begin
                check("model_out", out, ref_d[3]);
                check("model_zero", {15'd0, zero}, {15'd0, ref_d[3] == 16'h0000});
                check("model_neg", {15'd0, neg}, {15'd0, ref_d[3][15]});
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [3:0] s);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; in_valid = 1'b1; A = a; shamt = s;
    endtask

    task automatic bubble();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; A = 16'h0000; shamt = 4'd0;
    endtask

    // Issue one operation alone and check the result four enabled cycles later.
    task automatic single(input string name, input logic [15:0] a, input logic [3:0] s,
                          input logic [15:0] exp);
        issue(a, s);
        repeat (4) bubble();
        check({name, "_valid"}, {15'd0, out_valid}, 16'd1);
        check(name, out, exp);
        check({name, "_zero"}, {15'd0, zero}, {15'd0, exp == 16'h0000});
        check({name, "_neg"}, {15'd0, neg}, {15'd0, exp[15]});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_out", out, 16'h0000);
        check("reset_valid", {15'd0, out_valid}, 16'd0);
        check("reset_zero", {15'd0, zero}, 16'd1);
        check("reset_neg", {15'd0, neg}, 16'd0);
        chk_on = 1'b1;

        single("basic", 16'd8, 4'd2, 16'd2);
        single("signfill_1", 16'h8001, 4'd1, 16'hC000);
        single("signfill_15", 16'h8000, 4'd15, 16'hFFFF);
        single("pos_15", 16'h7FFF, 4'd15, 16'h0000);
        single("shift_0", 16'hA5A5, 4'd0, 16'hA5A5);
        single("sweep_4", 16'h9234, 4'd4, 16'hF923);
        single("sweep_8", 16'h9234, 4'd8, 16'hFF92);

        for (int s = 0; s < 16; s++) issue(16'h9234, s[3:0]);
        repeat (4) bubble();

        for (int i = 0; i < 8; i++) issue(16'($urandom), 4'($urandom_range(0, 15)));
        repeat (4) bubble();

        // Stall with two operations in flight.
        issue(16'hF000, 4'd4);
        issue(16'h1234, 4'd3);
        bubble();
        bubble();
        @(negedge clk);
        en = 1'b0; in_valid = 1'b1; A = 16'h5555; shamt = 4'd1;
        held_out = out;
        held_v   = out_valid;
        check("stall_first_valid", {15'd0, held_v}, 16'd1);
        check("stall_first_out", held_out, 16'hFF00);
        repeat (3) begin
            @(negedge clk);
            check("stall_hold_out", out, held_out);
            check("stall_hold_valid", {15'd0, out_valid}, {15'd0, held_v});
        end
        bubble();
        bubble();
        check("stall_second_valid", {15'd0, out_valid}, 16'd1);
        check("stall_second_out", out, 16'h0246);
        repeat (3) bubble();

        // Reset with three operations in flight, input presented during reset.
        issue(16'h8000, 4'd3);
        issue(16'h4000, 4'd2);
        issue(16'hFFFF, 4'd1);
        @(negedge clk);
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; A = 16'h7777; shamt = 4'd2;
        repeat (4) begin
            bubble();
            check("rst_flush_valid", {15'd0, out_valid}, 16'd0);
            check("rst_flush_out", out, 16'h0000);
            check("rst_flush_zero", {15'd0, zero}, 16'd1);
        end
        single("after_reset", 16'h0400, 4'd5, 16'h0020);

        repeat (2) bubble();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sra_shift_unit.md
Name: sra_shift_unit

Overview:
- Clocked 16-bit arithmetic shift-right unit for the CPU-16 ALU datapath.
- Shifts a signed operand right by a 4-bit amount, replicating the sign bit into vacated MSBs.
- Implemented as a 4-stage pipelined logarithmic barrel shifter; each stage handles one bit of the shift amount.
- Valid bits travel with data; a global enable stalls the pipeline.

Parameters:
- WIDTH, 16, operand/result width in bits (fixed at 16 for CPU-16; other values need not be supported).
- SHW, 4, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  pipeline advance enable; 0 = all stage registers hold.
- in_valid  input  1  A/shamt are valid this cycle; sampled only when en=1.
- A  input  16  operand, two's-complement signed.
- shamt  input  4  shift amount, unsigned 0..15.
- out  output  16  result, A >>> shamt.
- out_valid  output  1  out/zero/neg are valid.
- zero  output  1  1 when out == 16'h0000.
- neg  output  1  out[15].

Behaviour:
- Arithmetic rule: out = A >>> shamt (signed). Vacated MSBs are filled with A[15]. Bits shifted past bit 0 are discarded.
  - shamt = 0: out equals A.
  - shamt = 15: out is 16'hFFFF if A[15]=1, else 16'h0000.
- Stage k (k = 0..3): if the carried shamt bit k is 1, shift right by 2^k with sign fill; otherwise pass through.
  - Stage 0 = shift by 1, stage 1 = shift by 2, stage 2 = shift by 4, stage 3 = shift by 8.
  - Stage order is fixed 1, 2, 4, 8.
- Each stage registers: data, remaining shamt bits, and valid.
- Sign fill always uses the current stage's data MSB, which equals the original A[15].
- Latency: exactly 4 enabled cycles from sampling in_valid=1 to out_valid=1.
- Throughput: one operation per enabled cycle. No bubbles are inserted.
- Stall (en=0): every stage register holds, including data, shamt and valid. Outputs hold steady. Inputs are ignored that cycle.
- in_valid=0 with en=1: a bubble (valid=0) enters stage 0. Data registers may load don't-care values.
- Output flags:
  - zero and neg are derived combinationally from the final stage data register.
  - When out_valid=0 they are don't-care, but the implementation shall drive them from the register contents, with no X-propagation.
- Reset (rst=1 at a rising edge), taking priority over en:
  - all stage valid bits cleared to 0;
  - all data registers cleared to 16'h0000;
  - all shamt registers cleared to 0;
  - consequently out=0, out_valid=0, zero=1, neg=0.
- Reset mid-operation: in-flight operations are discarded and never emerge.
- First operation after reset: if sampled on the first cycle rst=0 with en=1, it appears 4 cycles later.
- Simultaneous rst=1 and in_valid=1: the input is dropped.
- No overflow or carry output. An arithmetic right shift cannot overflow.

Test Plan:
- Basic: A=16'd8, shamt=2, in_valid=1, en=1 held -> after 4 cycles out=16'd2, out_valid=1, zero=0, neg=0.
- Sign fill: A=16'h8001, shamt=1 -> out=16'hC000, neg=1. Then A=16'h8000, shamt=15 -> out=16'hFFFF.
- Boundaries:
  - A=16'h7FFF, shamt=15 -> out=16'h0000, zero=1.
  - A=16'hA5A5, shamt=0 -> out=16'hA5A5.
  - All 16 shamt values on A=16'h9234 checked against a signed reference model.
- Back-to-back stream: 8 consecutive random operations -> 8 consecutive out_valid=1 results, in order, each matching A>>>shamt.
- Stall: issue 2 operations, hold en=0 for 3 cycles mid-pipe -> outputs and valid frozen during the stall. Results emerge in order after en=1, with total latency 4 enabled cycles.
- Reset: assert rst for 1 cycle with 3 operations in flight -> out_valid stays 0 for the following 4 cycles, out=0, zero=1. A new operation issued after reset returns the correct result.
